// File: rtl/coherence_mem_interface.sv
// Memory-port agent on the coherence bus: latches a memory request, runs a word-serial
// burst to lower memory, then returns the completion message and response line.
module coherence_mem_interface #(
    parameter int MSG_BITS    = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int CACHE_WORDS = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              req_ready,
    input  logic [MSG_BITS-1:0]               bus_msg,
    input  logic [ADDR_WIDTH-1:0]             bus_address,
    input  logic [DATA_WIDTH*CACHE_WORDS-1:0] bus_data,
    input  logic                              bus_shared,
    output logic [MSG_BITS-1:0]               mem2controller_msg,
    output logic [MSG_BITS-1:0]               mem_bus_msg,
    output logic [ADDR_WIDTH-1:0]             mem_bus_address,
    output logic [DATA_WIDTH*CACHE_WORDS-1:0] mem_bus_data,
    output logic                              mem_req_valid,
    output logic                              mem_req_write,
    output logic [ADDR_WIDTH-1:0]             mem_req_addr,
    output logic [DATA_WIDTH-1:0]             mem_req_data,
    input  logic                              mem_req_ready,
    input  logic                              mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]             mem_resp_data
);

    localparam int OFF = $clog2(CACHE_WORDS);
    localparam int BW  = OFF + 1;
    localparam int LW  = DATA_WIDTH * CACHE_WORDS;

    localparam logic [MSG_BITS-1:0] NO_REQ     = MSG_BITS'(0);
    localparam logic [MSG_BITS-1:0] R_REQ      = MSG_BITS'(1);
    localparam logic [MSG_BITS-1:0] RFO_BCAST  = MSG_BITS'(2);
    localparam logic [MSG_BITS-1:0] WB_REQ     = MSG_BITS'(3);
    localparam logic [MSG_BITS-1:0] FLUSH      = MSG_BITS'(5);
    localparam logic [MSG_BITS-1:0] FLUSH_S    = MSG_BITS'(6);
    localparam logic [MSG_BITS-1:0] MEM_RESP   = MSG_BITS'(7);
    localparam logic [MSG_BITS-1:0] MEM_RESP_S = MSG_BITS'(8);
    localparam logic [MSG_BITS-1:0] C_WB       = MSG_BITS'(11);
    localparam logic [MSG_BITS-1:0] C_FLUSH    = MSG_BITS'(12);
    localparam logic [MSG_BITS-1:0] MEM_C_RESP = MSG_BITS'(13);

    localparam logic [BW-1:0]         BEAT_LAST = BW'(CACHE_WORDS - 1);
    localparam logic [BW-1:0]         BEAT_SAT  = BW'(CACHE_WORDS);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(CACHE_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE, WR_BURST, WR_ACK, RD_ADDR, RD_BEATS, RESPOND
    } state_t;

    state_t                r_state;
    logic                  r_req_ready_q;
    logic [MSG_BITS-1:0]   r_msg;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [LW-1:0]         r_line;
    logic                  r_shared;
    logic [BW-1:0]         r_beat;

    logic                  w_edge;
    logic                  w_is_write;
    logic                  w_is_read;
    logic [BW-1:0]         w_beat_nxt;
    logic                  w_last;
    logic [MSG_BITS-1:0]   w_resp;

    assign w_edge     = req_ready & ~r_req_ready_q;
    assign w_is_write = (bus_msg == WB_REQ) || (bus_msg == FLUSH) || (bus_msg == FLUSH_S) ||
                        (bus_msg == C_WB) || (bus_msg == C_FLUSH);
    assign w_is_read  = (bus_msg == R_REQ) || (bus_msg == RFO_BCAST);
    assign w_beat_nxt = (r_beat == BEAT_SAT) ? r_beat : r_beat + BW'(1);
    assign w_last     = (r_beat == BEAT_LAST);

    always_comb begin
        w_resp = MEM_RESP;
        if ((r_msg == C_WB) || (r_msg == C_FLUSH)) begin
            w_resp = MEM_C_RESP;
        end else if ((r_msg == R_REQ) && r_shared) begin
            w_resp = MEM_RESP_S;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state            <= IDLE;
            r_req_ready_q      <= 1'b0;
            r_msg              <= NO_REQ;
            r_base             <= '0;
            r_line             <= '0;
            r_shared           <= 1'b0;
            r_beat             <= '0;
            mem2controller_msg <= NO_REQ;
            mem_bus_msg        <= NO_REQ;
            mem_bus_address    <= '0;
            mem_bus_data       <= '0;
            mem_req_valid      <= 1'b0;
            mem_req_write      <= 1'b0;
            mem_req_addr       <= '0;
            mem_req_data       <= '0;
        end else begin
            r_req_ready_q      <= req_ready;
            mem2controller_msg <= NO_REQ;
            case (r_state)
                IDLE: begin
                    if (w_edge && (w_is_write || w_is_read)) begin
                        r_msg         <= bus_msg;
                        r_base        <= bus_address & ~OFF_MASK;
                        r_line        <= bus_data;
                        r_shared      <= bus_shared;
                        r_beat        <= '0;
                        mem_bus_msg   <= NO_REQ;
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= bus_address & ~OFF_MASK;
                        if (w_is_write) begin
                            r_state       <= WR_BURST;
                            mem_req_write <= 1'b1;
                            mem_req_data  <= bus_data[DATA_WIDTH-1:0];
                        end else begin
                            r_state       <= RD_ADDR;
                            mem_req_write <= 1'b0;
                            mem_req_data  <= '0;
                        end
                    end
                end
                WR_BURST: begin
                    if (mem_req_ready) begin
                        if (w_last) begin
                            mem_req_valid <= 1'b0;
                            mem_req_write <= 1'b0;
                            r_state       <= WR_ACK;
                        end else begin
                            // Present the next beat straight away so the bus sees no bubble.
                            r_beat       <= w_beat_nxt;
                            mem_req_addr <= r_base | ADDR_WIDTH'(w_beat_nxt[OFF-1:0]);
                            mem_req_data <= r_line[int'(w_beat_nxt[OFF-1:0]) * DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
                WR_ACK: begin
                    if (mem_resp_valid) begin
                        r_state <= RESPOND;
                    end
                end
                RD_ADDR: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        r_beat        <= '0;
                        r_state       <= RD_BEATS;
                    end
                end
                RD_BEATS: begin
                    if (mem_resp_valid && (r_beat != BEAT_SAT)) begin
                        r_line[int'(r_beat[OFF-1:0]) * DATA_WIDTH +: DATA_WIDTH] <= mem_resp_data;
                        r_beat <= w_beat_nxt;
                        if (w_last) begin
                            r_state <= RESPOND;
                        end
                    end
                end
                RESPOND: begin
                    mem2controller_msg <= w_resp;
                    mem_bus_msg        <= w_resp;
                    mem_bus_address    <= r_base;
                    mem_bus_data       <= r_line;
                    r_state            <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coherence_mem_interface.sv
// Directed bench for coherence_mem_interface: read/write bursts, response encoding,
// edge-only acceptance, reset mid-burst and back-to-back requests.
module tb_coherence_mem_interface;

    localparam int MSG_BITS    = 4;
    localparam int ADDR_WIDTH  = 32;
    localparam int DATA_WIDTH  = 32;
    localparam int CACHE_WORDS = 4;
    localparam int LW          = DATA_WIDTH * CACHE_WORDS;

    localparam logic [3:0] NO_REQ     = 4'd0;
    localparam logic [3:0] R_REQ      = 4'd1;
    localparam logic [3:0] RFO_BCAST  = 4'd2;
    localparam logic [3:0] WB_REQ     = 4'd3;
    localparam logic [3:0] FLUSH      = 4'd5;
    localparam logic [3:0] FLUSH_S    = 4'd6;
    localparam logic [3:0] MEM_RESP   = 4'd7;
    localparam logic [3:0] MEM_RESP_S = 4'd8;
    localparam logic [3:0] C_WB       = 4'd11;
    localparam logic [3:0] C_FLUSH    = 4'd12;
    localparam logic [3:0] MEM_C_RESP = 4'd13;

    logic                  clock;
    logic                  reset;
    logic                  req_ready;
    logic [MSG_BITS-1:0]   bus_msg;
    logic [ADDR_WIDTH-1:0] bus_address;
    logic [LW-1:0]         bus_data;
    logic                  bus_shared;
    logic [MSG_BITS-1:0]   mem2controller_msg;
    logic [MSG_BITS-1:0]   mem_bus_msg;
    logic [ADDR_WIDTH-1:0] mem_bus_address;
    logic [LW-1:0]         mem_bus_data;
    logic                  mem_req_valid;
    logic                  mem_req_write;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [DATA_WIDTH-1:0] mem_req_data;
    logic                  mem_req_ready;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_resp_data;

    int n_checks = 0;
    int n_fail   = 0;

    coherence_mem_interface #(
        .MSG_BITS(MSG_BITS), .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .CACHE_WORDS(CACHE_WORDS)
    ) dut (
        .clock(clock), .reset(reset), .req_ready(req_ready),
        .bus_msg(bus_msg), .bus_address(bus_address), .bus_data(bus_data),
        .bus_shared(bus_shared), .mem2controller_msg(mem2controller_msg),
        .mem_bus_msg(mem_bus_msg), .mem_bus_address(mem_bus_address),
        .mem_bus_data(mem_bus_data), .mem_req_valid(mem_req_valid),
        .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] msg, input logic [31:0] addr, input logic [LW-1:0] line,
                         input logic sh, input bit hold);
        bus_msg     = msg;
        bus_address = addr;
        bus_data    = line;
        bus_shared  = sh;
        req_ready   = 1'b1;
        tick();
        if (!hold) req_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_m2c"}, LW'(mem2controller_msg), LW'(NO_REQ));
        check_eq({tag, "_busmsg"}, LW'(mem_bus_msg), LW'(NO_REQ));
        check_eq({tag, "_busdata"}, mem_bus_data, '0);
        check_eq({tag, "_busaddr"}, LW'(mem_bus_address), '0);
        check_eq({tag, "_valid"}, LW'(mem_req_valid), '0);
        check_eq({tag, "_addr"}, LW'(mem_req_addr), '0);
    endtask

    // Read with handshakes stepped by hand; memory returns first_word, first_word+1, ...
    task automatic read_stepped(input string tag, input logic [31:0] addr, input logic [31:0] first_word);
        logic [LW-1:0] exp_line;
        issue(R_REQ, addr, '0, 1'b0, 1'b0);
        check_eq({tag, "_req_valid"}, LW'(mem_req_valid), LW'(1));
        check_eq({tag, "_req_write"}, LW'(mem_req_write), LW'(0));
        check_eq({tag, "_req_addr"}, LW'(mem_req_addr), LW'(addr & ~32'h3));
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check_eq({tag, "_req_drop"}, LW'(mem_req_valid), LW'(0));
        exp_line = '0;
        for (int i = 0; i < CACHE_WORDS; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = first_word + 32'(i);
            exp_line[i*DATA_WIDTH +: DATA_WIDTH] = first_word + 32'(i);
            tick();
        end
        mem_resp_valid = 1'b0;
        check_eq({tag, "_not_early"}, LW'(mem2controller_msg), LW'(NO_REQ));
        tick();
        check_eq({tag, "_m2c"}, LW'(mem2controller_msg), LW'(MEM_RESP));
        check_eq({tag, "_busmsg"}, LW'(mem_bus_msg), LW'(MEM_RESP));
        check_eq({tag, "_busaddr"}, LW'(mem_bus_address), LW'(addr & ~32'h3));
        check_eq({tag, "_busdata"}, mem_bus_data, exp_line);
        tick();
        check_eq({tag, "_pulse"}, LW'(mem2controller_msg), LW'(NO_REQ));
        check_eq({tag, "_hold"}, LW'(mem_bus_msg), LW'(MEM_RESP));
    endtask

    // Lower memory ready/valid tied high; checks latency, beat counts and the response.
    task automatic run_tied(input string tag, input logic [3:0] msg, input logic [31:0] addr,
                            input logic [LW-1:0] line, input logic sh, input logic [3:0] exp_msg,
                            input bit hold);
        int  k, wbeats, rreqs;
        bit  is_wr;
        logic [LW-1:0] exp_line;
        is_wr = (msg == WB_REQ) || (msg == FLUSH) || (msg == FLUSH_S) || (msg == C_WB) || (msg == C_FLUSH);
        exp_line = is_wr ? line : {CACHE_WORDS{32'h0000_0077}};
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0000_0077;
        issue(msg, addr, line, sh, hold);
        check_eq({tag, "_accept_clr"}, LW'(mem_bus_msg), LW'(NO_REQ));
        k = 0; wbeats = 0; rreqs = 0;
        while ((mem2controller_msg == NO_REQ) && (k < 20)) begin
            if (mem_req_valid) begin
                if (mem_req_write) wbeats++;
                else rreqs++;
            end
            tick();
            k++;
        end
        check_eq({tag, "_latency"}, LW'(k), LW'(CACHE_WORDS + 2));
        check_eq({tag, "_m2c"}, LW'(mem2controller_msg), LW'(exp_msg));
        check_eq({tag, "_busmsg"}, LW'(mem_bus_msg), LW'(exp_msg));
        check_eq({tag, "_busaddr"}, LW'(mem_bus_address), LW'(addr & ~32'h3));
        check_eq({tag, "_busdata"}, mem_bus_data, exp_line);
        check_eq({tag, "_wbeats"}, LW'(wbeats), LW'(is_wr ? CACHE_WORDS : 0));
        check_eq({tag, "_rreqs"}, LW'(rreqs), LW'(is_wr ? 0 : 1));
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        tick();
        check_eq({tag, "_pulse"}, LW'(mem2controller_msg), LW'(NO_REQ));
    endtask

    initial begin
        logic [LW-1:0] wb_line;
        int            cnt;
        reset = 1'b1; req_ready = 1'b0; bus_msg = NO_REQ; bus_address = '0; bus_data = '0;
        bus_shared = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check_reset_outputs("rst");

        read_stepped("rd1", 32'h0000_0100, 32'h0000_00A0);

        // Write-back with a stalling memory: every beat must hold steady while ready is low.
        wb_line = {32'd4, 32'd3, 32'd2, 32'd1};
        issue(WB_REQ, 32'h0000_0107, wb_line, 1'b0, 1'b0);
        check_eq("wb_accept_clr", LW'(mem_bus_msg), LW'(NO_REQ));
        for (int b = 0; b < CACHE_WORDS; b++) begin
            check_eq($sformatf("wb_valid%0d", b), LW'(mem_req_valid & mem_req_write), LW'(1));
            check_eq($sformatf("wb_addr%0d", b), LW'(mem_req_addr), LW'(32'h104 + 32'(b)));
            check_eq($sformatf("wb_data%0d", b), LW'(mem_req_data), LW'(b + 1));
            mem_req_ready = 1'b0;
            tick();
            check_eq($sformatf("wb_stall_addr%0d", b), LW'(mem_req_addr), LW'(32'h104 + 32'(b)));
            check_eq($sformatf("wb_stall_data%0d", b), LW'(mem_req_data), LW'(b + 1));
            mem_req_ready = 1'b1;
            tick();
            mem_req_ready = 1'b0;
        end
        check_eq("wb_req_drop", LW'(mem_req_valid), LW'(0));
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        tick();
        check_eq("wb_m2c", LW'(mem2controller_msg), LW'(MEM_RESP));
        check_eq("wb_busaddr", LW'(mem_bus_address), LW'(32'h104));
        check_eq("wb_busdata", mem_bus_data, wb_line);
        tick();

        run_tied("rds", R_REQ, 32'h0000_0200, '0, 1'b1, MEM_RESP_S, 1'b0);
        run_tied("cfl", C_FLUSH, 32'h0000_0302, {32'hD, 32'hC, 32'hB, 32'hA}, 1'b0, MEM_C_RESP, 1'b0);

        // req_ready left high through RESPOND and back into IDLE must not retrigger.
        run_tied("hold", R_REQ, 32'h0000_0700, '0, 1'b0, MEM_RESP, 1'b1);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_req_valid) cnt++;
        end
        check_eq("hold_no_retrigger", LW'(cnt), LW'(0));
        req_ready = 1'b0;
        tick();
        issue(NO_REQ, 32'h0000_0800, '0, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (mem_req_valid) cnt++;
            tick();
        end
        check_eq("noreq_ignored", LW'(cnt), LW'(0));
        check_eq("noreq_busmsg", LW'(mem_bus_msg), LW'(MEM_RESP));

        // Reset in the middle of a read burst, followed by stray memory beats.
        issue(R_REQ, 32'h0000_0400, '0, 1'b0, 1'b0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'h0000_00B0 + 32'(i);
            tick();
        end
        mem_resp_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs("midrst");
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0000_DEAD;
        tick(); tick();
        mem_resp_valid = 1'b0;
        tick();
        check_reset_outputs("stray");
        read_stepped("rd2", 32'h0000_0400, 32'h0000_00C0);

        // Back-to-back: write-back then RFO; shared is set but RFO still answers MEM_RESP.
        run_tied("b2b_wb", WB_REQ, 32'h0000_0500, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b0, MEM_RESP, 1'b0);
        run_tied("b2b_rfo", RFO_BCAST, 32'h0000_0601, '0, 1'b1, MEM_RESP, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
